// File: rtl/gpa_fhdo_defs.sv
// Shared definitions for the GPA-FHDO board SPI master: frame lengths,
// ADC read-back offset and FSM state encoding.
package gpa_fhdo_defs;

  localparam int DAC_BITS   = 24;
  localparam int ADC_BITS   = 32;
  localparam int ADC_RD_OFS = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DESEL = 3'd1,
    ST_LEAD  = 3'd2,
    ST_SHIFT = 3'd3,
    ST_TRAIL = 3'd4,
    ST_GAP   = 3'd5
  } state_t;

endpackage

// File: rtl/gpa_fhdo_spi.sv
// SPI master for the GPA-FHDO gradient board: 24-bit DAC writes and 32-bit
// ADC frames sharing one chip-select line, SCLK idle high, all outputs registered.
module gpa_fhdo_spi
  import gpa_fhdo_defs::*;
#(
  parameter int DIV_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [23:0]      data_i,
  input  logic             adc_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [DIV_W-1:0] clk_div_i,
  output logic             csn_o,
  output logic             sclk_o,
  output logic             sdo_o,
  input  logic             sdi_i,
  output logic [15:0]      adc_data_o,
  output logic             adc_valid_o
);

  state_t           state_q, state_n;
  logic [DIV_W-1:0] cnt_q, cnt_n;
  logic [DIV_W-1:0] div_q, div_n;
  logic             adc_q, adc_n;
  logic             phase_q, phase_n;
  logic [4:0]       bit_q, bit_n;
  logic [31:0]      shreg_q, shreg_n;
  logic [15:0]      rx_q, rx_n;

  logic             ready_n, csn_n, sclk_n, sdo_n;
  logic [15:0]      adc_data_n;
  logic             adc_valid_n;
  logic             last;
  logic [4:0]       last_bit;

  assign last     = (cnt_q == '0);
  assign last_bit = adc_q ? 5'(ADC_BITS - 1) : 5'(DAC_BITS - 1);

  always_comb begin
    state_n     = state_q;
    cnt_n       = cnt_q;
    div_n       = div_q;
    adc_n       = adc_q;
    phase_n     = phase_q;
    bit_n       = bit_q;
    shreg_n     = shreg_q;
    rx_n        = rx_q;
    adc_data_n  = adc_data_o;
    adc_valid_n = 1'b0;

    if (state_q == ST_IDLE) begin
      if (valid_i) begin
        div_n   = clk_div_i;
        cnt_n   = clk_div_i;
        adc_n   = adc_i;
        phase_n = 1'b0;
        bit_n   = '0;
        shreg_n = adc_i ? {data_i[23:8], 16'h0000} : {data_i, 8'h00};
        state_n = adc_i ? ST_DESEL : ST_LEAD;
      end
    end else if (!last) begin
      cnt_n = cnt_q - 1'b1;
    end else begin
      // Phase boundary: reload the half-period counter and advance.
      cnt_n = div_q;
      case (state_q)
        ST_DESEL: state_n = ST_LEAD;
        ST_LEAD:  state_n = ST_SHIFT;
        ST_SHIFT: begin
          if (!phase_q) begin
            phase_n = 1'b1;
            if (adc_q && bit_q >= 5'(ADC_RD_OFS))
              rx_n = {rx_q[14:0], sdi_i};
          end else begin
            phase_n = 1'b0;
            shreg_n = {shreg_q[30:0], 1'b0};
            if (bit_q == last_bit)
              state_n = ST_TRAIL;
            else
              bit_n = bit_q + 1'b1;
          end
        end
        ST_TRAIL: begin
          if (adc_q) begin
            state_n     = ST_IDLE;
            adc_data_n  = rx_q;
            adc_valid_n = 1'b1;
          end else begin
            state_n = ST_GAP;
          end
        end
        ST_GAP:  state_n = ST_IDLE;
        default: state_n = ST_IDLE;
      endcase
    end

    // Pin values follow the next state so every output is a flop.
    ready_n = (state_n == ST_IDLE);
    sclk_n  = !(state_n == ST_SHIFT && phase_n);
    case (state_n)
      ST_IDLE, ST_GAP: csn_n = 1'b1;
      ST_DESEL:        csn_n = 1'b0;
      default:         csn_n = adc_n;
    endcase
    case (state_n)
      ST_LEAD, ST_SHIFT, ST_TRAIL: sdo_n = shreg_n[31];
      default:                     sdo_n = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      bit_q       <= '0;
      phase_q     <= 1'b0;
      adc_q       <= 1'b0;
      ready_o     <= 1'b1;
      csn_o       <= 1'b1;
      sclk_o      <= 1'b1;
      sdo_o       <= 1'b0;
      adc_data_o  <= '0;
      adc_valid_o <= 1'b0;
    end else begin
      state_q     <= state_n;
      cnt_q       <= cnt_n;
      bit_q       <= bit_n;
      phase_q     <= phase_n;
      adc_q       <= adc_n;
      ready_o     <= ready_n;
      csn_o       <= csn_n;
      sclk_o      <= sclk_n;
      sdo_o       <= sdo_n;
      adc_data_o  <= adc_data_n;
      adc_valid_o <= adc_valid_n;
    end
  end

  // Datapath registers are always (re)loaded before use, so no reset.
  always_ff @(posedge clk) begin
    div_q   <= div_n;
    shreg_q <= shreg_n;
    rx_q    <= rx_n;
  end

endmodule

// File: tb/tb_gpa_fhdo_spi.sv
// Directed bench for gpa_fhdo_spi with a DAC register model and an ADC responder.
module tb_gpa_fhdo_spi;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] data_i = '0;
  logic        adc_i = 1'b0;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic [5:0]  clk_div_i = '0;
  logic        csn_o, sclk_o, sdo_o;
  logic        sdi_i;
  logic [15:0] adc_data_o;
  logic        adc_valid_o;

  gpa_fhdo_spi #(.DIV_W(6)) dut (
    .clk(clk), .rst(rst), .data_i(data_i), .adc_i(adc_i), .valid_i(valid_i),
    .ready_o(ready_o), .clk_div_i(clk_div_i), .csn_o(csn_o), .sclk_o(sclk_o),
    .sdo_o(sdo_o), .sdi_i(sdi_i), .adc_data_o(adc_data_o), .adc_valid_o(adc_valid_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Board model state
  logic [15:0] vout [4];
  logic [15:0] adc_resp = '0;
  logic [31:0] adc_word;
  logic [31:0] msr = '0;
  int mbits = 0, frames24 = 0, pulses = 0, csn_low = 0, accepts = 0;
  int cyc = 0, last_rise = -1, per_min = 0, per_max = 0;
  logic sclk_prev = 1'b1, csn_prev = 1'b1;
  int tog = 0, pulse_at = -1;

  assign adc_word = {16'h0000, adc_resp};
  always_comb begin
    sdi_i = 1'b0;
    if (mbits < 32) sdi_i = adc_word[5'(31 - mbits)];
  end

  always @(posedge clk) if (!rst && valid_i && ready_o) accepts++;

  always @(negedge clk) begin
    int idx;
    cyc++;
    if (!csn_o) csn_low++;
    if (adc_valid_o) pulses++;
    if (csn_prev && !csn_o) begin
      mbits = 0;
      msr = '0;
    end else if (sclk_prev && !sclk_o) begin
      msr = {msr[30:0], sdo_o};
      mbits++;
    end
    if (!sclk_prev && sclk_o) begin
      if (last_rise >= 0) begin
        if (cyc - last_rise < per_min) per_min = cyc - last_rise;
        if (cyc - last_rise > per_max) per_max = cyc - last_rise;
      end
      last_rise = cyc;
    end
    if (!csn_prev && csn_o && mbits == 24) begin
      idx = int'(msr[19:16]) - 4;
      if (idx >= 0 && idx < 4) vout[idx] = msr[15:0];
      frames24++;
    end
    sclk_prev = sclk_o;
    csn_prev = csn_o;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic reset_stats();
    csn_low = 0; pulses = 0; last_rise = -1; per_min = 1 << 30; per_max = 0;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!ready_o && n < 5000) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic run_frame(input logic [23:0] d, input logic a, input logic [5:0] dv,
                           output int busy);
    wait_ready();
    @(negedge clk);
    reset_stats();
    data_i = d; adc_i = a; clk_div_i = dv; valid_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0;
    busy = 0;
    while (!ready_o && busy < 5000) begin
      busy++;
      if (tog != 0 && busy % 7 == 0) clk_div_i = clk_div_i ^ 6'h3F;
      if (busy == pulse_at) begin
        valid_i = 1'b1;
        data_i  = 24'h043333;
      end else begin
        valid_i = 1'b0;
      end
      @(negedge clk);
    end
    valid_i = 1'b0;
    @(negedge clk);
    #1;
  endtask

  typedef struct {
    logic [23:0] d;
    logic        a;
    logic [5:0]  dv;
    int          busy;
    int          csn;
    int          per;
    logic [15:0] val;
  } vec_t;

  vec_t vt [7];

  initial begin
    int busy, f0, a0, lows, gaps, n;
    for (int i = 0; i < 4; i++) vout[i] = '0;

    vt[0] = '{24'h048000, 1'b0, 6'd0,  51,   50,   2,   16'h8000};
    vt[1] = '{24'h071234, 1'b0, 6'd3,  204,  200,  8,   16'h1234};
    vt[2] = '{24'h05ABCD, 1'b0, 6'd1,  102,  100,  4,   16'hABCD};
    vt[3] = '{24'h065A5A, 1'b0, 6'd2,  153,  150,  6,   16'h5A5A};
    vt[4] = '{24'h810000, 1'b1, 6'd0,  67,   1,    2,   16'hABCD};
    vt[5] = '{24'hC23456, 1'b1, 6'd2,  201,  3,    6,   16'h5A5A};
    vt[6] = '{24'h04FFFF, 1'b0, 6'd63, 3264, 3200, 128, 16'hFFFF};

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_ready", ready_o, 1);
    chk("rst_csn", csn_o, 1);
    chk("rst_sclk", sclk_o, 1);
    chk("rst_sdo", sdo_o, 0);
    chk("rst_adc_data", adc_data_o, 0);
    chk("rst_adc_valid", adc_valid_o, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 7; i++) begin
      f0 = frames24;
      if (vt[i].a) adc_resp = vout[vt[i].d[17:16]];
      run_frame(vt[i].d, vt[i].a, vt[i].dv, busy);
      chk($sformatf("v%0d_busy", i), busy, vt[i].busy);
      chk($sformatf("v%0d_csn_low", i), csn_low, vt[i].csn);
      chk($sformatf("v%0d_per_min", i), per_min, vt[i].per);
      chk($sformatf("v%0d_per_max", i), per_max, vt[i].per);
      if (!vt[i].a) begin
        chk($sformatf("v%0d_frames", i), frames24 - f0, 1);
        chk($sformatf("v%0d_vout", i), vout[int'(vt[i].d[19:16]) - 4], vt[i].val);
      end else begin
        chk($sformatf("v%0d_pulses", i), pulses, 1);
        chk($sformatf("v%0d_adc_data", i), adc_data_o, vt[i].val);
        chk($sformatf("v%0d_tx_bits", i), mbits, 32);
        chk($sformatf("v%0d_tx_word", i), msr, {vt[i].d[23:8], 16'h0000});
        chk($sformatf("v%0d_frames", i), frames24 - f0, 0);
      end
    end

    // Back-to-back: valid held for three frames
    wait_ready();
    @(negedge clk);
    f0 = frames24; a0 = accepts; lows = 0; gaps = 0; n = 0;
    data_i = 24'h064444; adc_i = 1'b0; clk_div_i = 6'd0; valid_i = 1'b1;
    @(negedge clk);
    while (n < 1000) begin
      n++;
      if (accepts - a0 == 3) valid_i = 1'b0;
      if (ready_o) begin
        if (accepts - a0 == 3) break;
        gaps++;
      end else begin
        lows++;
      end
      @(negedge clk);
    end
    valid_i = 1'b0;
    @(negedge clk);
    #1;
    chk("b2b_accepts", accepts - a0, 3);
    chk("b2b_busy_cycles", lows, 153);
    chk("b2b_idle_gaps", gaps, 2);
    chk("b2b_frames", frames24 - f0, 3);
    chk("b2b_vout", vout[2], 16'h4444);

    // valid pulse while busy is dropped
    f0 = frames24; a0 = accepts; pulse_at = 10;
    run_frame(24'h042222, 1'b0, 6'd0, busy);
    pulse_at = -1;
    chk("drop_busy", busy, 51);
    chk("drop_accepts", accepts - a0, 1);
    chk("drop_frames", frames24 - f0, 1);
    chk("drop_vout", vout[0], 16'h2222);

    // clk_div_i toggled mid-frame
    tog = 1;
    run_frame(24'h061111, 1'b0, 6'd3, busy);
    tog = 0;
    chk("tog_busy", busy, 204);
    chk("tog_per_min", per_min, 8);
    chk("tog_per_max", per_max, 8);
    chk("tog_vout", vout[2], 16'h1111);

    // Reset at bit 10 of an ADC frame
    wait_ready();
    @(negedge clk);
    reset_stats();
    adc_resp = 16'h5555;
    data_i = 24'h810000; adc_i = 1'b1; clk_div_i = 6'd1; valid_i = 1'b1;
    @(negedge clk);
    valid_i = 1'b0;
    n = 0;
    while (mbits != 10 && n < 2000) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("mid_reached_bit10", mbits, 10);
    rst = 1'b1;
    #1;
    chk("mid_rst_ready", ready_o, 1);
    chk("mid_rst_csn", csn_o, 1);
    chk("mid_rst_sclk", sclk_o, 1);
    chk("mid_rst_sdo", sdo_o, 0);
    chk("mid_rst_adc_data", adc_data_o, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (200) @(negedge clk);
    #1;
    chk("mid_no_pulse", pulses, 0);
    f0 = frames24;
    run_frame(24'h057777, 1'b0, 6'd0, busy);
    chk("post_rst_busy", busy, 51);
    chk("post_rst_frames", frames24 - f0, 1);
    chk("post_rst_vout", vout[1], 16'h7777);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL timeout: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
